// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 on-chip SRAM endpoint with single-beat writes and INCR read bursts
// Ports:
//   aclk, areset           clock and synchronous active-high reset
//   ar*/r*                 read address and read data channels (one burst in flight, up to 16 beats)
//   aw*/w*/b*              write address, write data and write response channels (single beat)
// Parameters:
//   ADDR_W                 word-index bits; depth is 2^ADDR_W 32-bit words, upper address bits alias
//   RD_DELAY               idle cycles between the AR handshake and the first rvalid (0..15)
module axi_sram_slave #(
  parameter int ADDR_W = 12,
  parameter int RD_DELAY = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [3:0] DLY_LD = 4'(RD_DELAY > 0 ? RD_DELAY - 1 : 0);
  localparam bit NO_DLY = RD_DELAY == 0;
  logic [31:0] mem [2**ADDR_W];
  logic [1:0] r_state;
  logic [3:0] r_dly, r_beats, r_nbeats;
  logic [ADDR_W-1:0] r_idx, r_nidx;
  logic ar_hs, r_hs, r_launch;
  logic aw_full, w_full, aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] aw_idx, c_idx;
  logic [3:0] aw_id, w_strb, c_strb, c_id;
  logic [31:0] w_data, c_data;
  logic unused;
  assign unused = ^{arlen[7:4], arsize, arburst, wlast, araddr[31:ADDR_W+2], araddr[1:0],
                    awaddr[31:ADDR_W+2], awaddr[1:0]};
  assign arready = r_state == R_IDLE;
  assign rresp = 2'b00;
  assign bresp = 2'b00;
  assign ar_hs = arvalid & arready;
  assign r_hs = rvalid & rready;
  // A beat is launched (memory sampled into rdata) straight from the AR handshake when there is no
  // delay, when the wait countdown expires, or when an accepted beat still has successors.
  always_comb begin
    r_nidx = r_state == R_IDLE ? araddr[ADDR_W+1:2] : r_state == R_WAIT ? r_idx : r_idx + 1'b1;
    r_nbeats = r_state == R_IDLE ? arlen[3:0] : r_state == R_WAIT ? r_beats : r_beats - 1'b1;
    r_launch = r_state == R_IDLE ? ar_hs & NO_DLY :
               r_state == R_WAIT ? r_dly == 4'd0 : r_hs & (r_beats != 4'd0);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_dly <= 4'd0;
      r_beats <= 4'd0;
      r_idx <= '0;
      rid <= 4'd0;
      rdata <= 32'd0;
      rlast <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      if (ar_hs) begin
        rid <= arid;
        r_idx <= araddr[ADDR_W+1:2];
        r_beats <= arlen[3:0];
        r_dly <= DLY_LD;
        r_state <= R_WAIT;
      end
      if (r_state == R_WAIT) r_dly <= r_dly - 1'b1;
      if (r_hs && r_beats == 4'd0) begin
        rvalid <= 1'b0;
        rlast <= 1'b0;
        r_state <= R_IDLE;
      end
      if (r_launch) begin
        r_idx <= r_nidx;
        r_beats <= r_nbeats;
        rdata <= mem[r_nidx];
        rlast <= r_nbeats == 4'd0;
        rvalid <= 1'b1;
        r_state <= R_DATA;
      end
    end
  end
  assign awready = ~aw_full & ~bvalid;
  assign wready = ~w_full & ~bvalid;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  // The commit bypasses the holding registers so a write completes on the edge where its second
  // half is accepted; bvalid then appears in the very next cycle.
  always_comb begin
    commit = (aw_full | aw_hs) & (w_full | w_hs);
    c_idx = aw_full ? aw_idx : awaddr[ADDR_W+1:2];
    c_id = aw_full ? aw_id : awid;
    c_data = w_full ? w_data : wdata;
    c_strb = w_full ? w_strb : wstrb;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      aw_id <= 4'd0;
      w_data <= 32'd0;
      w_strb <= 4'd0;
      bvalid <= 1'b0;
      bid <= 4'd0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx <= awaddr[ADDR_W+1:2];
        aw_id <= awid;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
        bvalid <= 1'b1;
        bid <= c_id;
      end
    end
  end
  always_ff @(posedge aclk)
    if (!areset && commit)
      for (int i = 0; i < 4; i++)
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed table and sequence checks for axi_sram_slave (RD_DELAY=1 and RD_DELAY=0)
module tb_axi_sram_slave;
  logic aclk = 1'b0;
  logic areset;
  logic [3:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;
  logic [3:0] z_arid, z_rid, z_bid;
  logic [31:0] z_araddr, z_rdata;
  logic [7:0] z_arlen;
  logic [1:0] z_rresp, z_bresp;
  logic z_arvalid, z_arready, z_rlast, z_rvalid, z_rready, z_awready, z_wready, z_bvalid;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exq [16];
  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] ra;
    logic [31:0] ex;
  } vec_t;
  vec_t tbl [7];
  always #5 aclk = ~aclk;
  axi_sram_slave #(.ADDR_W(12), .RD_DELAY(1)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  axi_sram_slave #(.ADDR_W(12), .RD_DELAY(0)) dut0 (
    .aclk(aclk), .areset(areset),
    .arid(z_arid), .araddr(z_araddr), .arlen(z_arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(z_arvalid), .arready(z_arready),
    .rid(z_rid), .rdata(z_rdata), .rresp(z_rresp), .rlast(z_rlast), .rvalid(z_rvalid), .rready(z_rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(z_awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(z_wready),
    .bid(z_bid), .bresp(z_bresp), .bvalid(z_bvalid), .bready(bready)
  );
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [3:0] id);
    awaddr = a; awid = id; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    chk("wr_awready", awready, 1);
    chk("wr_wready", wready, 1);
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bid", bid, id);
    chk("wr_bresp", bresp, 0);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("wr_bdone", bvalid, 0);
  endtask
  task automatic burst(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id, input int n, input bit stall);
    int lat, got;
    lat = 1; got = 0;
    araddr = a; arlen = len; arid = id; arvalid = 1'b1;
    chk("rd_arready", arready, 1);
    tick;
    arvalid = 1'b0;
    chk("rd_arbusy", arready, 0);
    while (!rvalid && lat < 20) begin
      tick;
      lat++;
    end
    chk("rd_latency", lat, 2);
    for (int k = 0; k < 40 && got < n; k++) begin
      chk("rd_rvalid", rvalid, 1);
      chk("rd_rdata", rdata, exq[got]);
      chk("rd_rlast", rlast, got == n - 1);
      chk("rd_rid", rid, id);
      chk("rd_rresp", rresp, 0);
      rready = stall ? (k % 3 != 1) : 1'b1;
      if (rvalid && rready) got++;
      tick;
    end
    rready = 1'b0;
    chk("rd_beats", got, n);
    chk("rd_end", rvalid, 0);
    chk("rd_idle", arready, 1);
  endtask
  task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [31:0] ex);
    exq[0] = ex;
    burst(a, 8'h00, id, 1, 1'b0);
  endtask
  task automatic zrd(input logic [31:0] a, input logic [3:0] id, input logic [31:0] ex);
    z_araddr = a; z_arid = id; z_arlen = 8'h00; z_arvalid = 1'b1;
    tick;
    z_arvalid = 1'b0;
    chk("z_rvalid", z_rvalid, 1);
    chk("z_rdata", z_rdata, ex);
    chk("z_rlast", z_rlast, 1);
    chk("z_rid", z_rid, id);
    z_rready = 1'b1;
    tick;
    z_rready = 1'b0;
    chk("z_rend", z_rvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{32'h0000_0000, 32'h0123_4567, 4'hF, 32'h0000_0000, 32'h0123_4567};
    tbl[1] = '{32'h0000_0000, 32'hAABB_CCDD, 4'h8, 32'h0000_0001, 32'hAA23_4567};
    tbl[2] = '{32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0000_0004, 32'hCAFE_F00D};
    tbl[3] = '{32'h0000_0004, 32'h0000_0000, 4'h5, 32'h0000_0006, 32'hCA00_F000};
    tbl[4] = '{32'h0000_4008, 32'h5A5A_5A5A, 4'hF, 32'h0000_0008, 32'h5A5A_5A5A};
    tbl[5] = '{32'h0000_0FFC, 32'h1357_9BDF, 4'hF, 32'h8000_0FFF, 32'h1357_9BDF};
    tbl[6] = '{32'h0000_3FFC, 32'hFEED_FACE, 4'hF, 32'h0000_7FFC, 32'hFEED_FACE};
    areset = 1'b1;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b1; wvalid = 1'b0;
    bready = 1'b0;
    z_arid = 4'd0; z_araddr = 32'd0; z_arlen = 8'd0; z_arvalid = 1'b0; z_rready = 1'b0;
    repeat (3) tick;
    areset = 1'b0;
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_z_rvalid", z_rvalid, 0);
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].wa, tbl[i].wd, tbl[i].ws, 4'(i));
      rd(tbl[i].ra, 4'(i + 1), tbl[i].ex);
    end
    exq[0] = 32'hFEED_FACE; exq[1] = 32'hAA23_4567;
    burst(32'h0000_3FFC, 8'h01, 4'hA, 2, 1'b0);
    wr(32'h40, 32'hDEAD_BEEF, 4'hF, 4'h1);
    rd(32'h40, 4'h0, 32'hDEAD_BEEF);
    wdata = 32'h1122_3344; wstrb = 4'b0011; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    chk("wfirst_bvalid", bvalid, 0);
    tick;
    chk("wfirst_awready2", awready, 1);
    chk("wfirst_bvalid2", bvalid, 0);
    awaddr = 32'h40; awid = 4'h2; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("wfirst_bvalid3", bvalid, 1);
    chk("wfirst_bid", bid, 4'h2);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    rd(32'h40, 4'h3, 32'hDEAD_3344);
    for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 32'(i + 1), 4'hF, 4'h4);
    for (int i = 0; i < 4; i++) exq[i] = 32'(i + 1);
    burst(32'h100, 8'hF3, 4'h5, 4, 1'b1);
    awaddr = 32'h80; awid = 4'h6; awvalid = 1'b1; wdata = 32'h8080_8080; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    awaddr = 32'h84; awid = 4'h7;
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid", bvalid, 1);
      chk("bstall_bid", bid, 4'h6);
      chk("bstall_awready", awready, 0);
      chk("bstall_wready", wready, 0);
      tick;
    end
    bready = 1'b1;
    chk("bstall_bvalid_end", bvalid, 1);
    tick;
    bready = 1'b0;
    chk("bstall_cleared", bvalid, 0);
    chk("bstall_awready_back", awready, 1);
    tick;
    awvalid = 1'b0;
    chk("bstall_aw_taken", awready, 0);
    chk("bstall_wready_open", wready, 1);
    wdata = 32'h8484_8484; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("bstall_b2valid", bvalid, 1);
    chk("bstall_b2id", bid, 4'h7);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    rd(32'h80, 4'h1, 32'h8080_8080);
    rd(32'h84, 4'h2, 32'h8484_8484);
    araddr = 32'h100; arlen = 8'h03; arid = 4'hC; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    tick;
    chk("mid_rvalid", rvalid, 1);
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    areset = 1'b1;
    repeat (3) tick;
    areset = 1'b0;
    chk("mid_rvalid_rst", rvalid, 0);
    chk("mid_rlast_rst", rlast, 0);
    chk("mid_rdata_rst", rdata, 0);
    chk("mid_rid_rst", rid, 0);
    chk("mid_bvalid_rst", bvalid, 0);
    chk("mid_bid_rst", bid, 0);
    chk("mid_arready_rst", arready, 1);
    chk("mid_awready_rst", awready, 1);
    chk("mid_wready_rst", wready, 1);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_stray_r", rvalid, 0);
      tick;
    end
    rready = 1'b0;
    awaddr = 32'h100; awid = 4'h3; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("mid_w_dropped", bvalid, 0);
    tick;
    chk("mid_w_dropped2", bvalid, 0);
    wdata = 32'h9999_9999; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("mid_bvalid", bvalid, 1);
    chk("mid_bid", bid, 4'h3);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    rd(32'h100, 4'h0, 32'h9999_9999);
    wr(32'h200, 32'hA5A5_0200, 4'hF, 4'h4);
    zrd(32'h200, 4'h8, 32'hA5A5_0200);
    awaddr = 32'h300; awid = 4'h5; awvalid = 1'b1; wdata = 32'h3333_3333; wstrb = 4'hF; wvalid = 1'b1;
    z_araddr = 32'h200; z_arid = 4'h9; z_arlen = 8'h00; z_arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; z_arvalid = 1'b0;
    chk("cc_z_rvalid", z_rvalid, 1);
    chk("cc_z_rdata", z_rdata, 32'hA5A5_0200);
    chk("cc_z_rid", z_rid, 4'h9);
    chk("cc_z_arbusy", z_arready, 0);
    chk("cc_z_bvalid", z_bvalid, 1);
    chk("cc_z_bid", z_bid, 4'h5);
    chk("cc_bvalid", bvalid, 1);
    bready = 1'b1; z_rready = 1'b1;
    tick;
    bready = 1'b0; z_rready = 1'b0;
    chk("cc_z_rend", z_rvalid, 0);
    chk("cc_z_bend", z_bvalid, 0);
    awaddr = 32'h200; awid = 4'h6; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    z_araddr = 32'h200; z_arid = 4'hB; z_arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; z_arvalid = 1'b0;
    chk("hz_old_data", z_rdata, 32'hA5A5_0200);
    chk("hz_z_rvalid", z_rvalid, 1);
    chk("hz_z_bvalid", z_bvalid, 1);
    bready = 1'b1; z_rready = 1'b1;
    tick;
    bready = 1'b0; z_rready = 1'b0;
    zrd(32'h200, 4'hD, 32'h1234_5678);
    rd(32'h300, 4'hE, 32'h3333_3333);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
